cycle_extract: RTL and testbench

Downstream of the Bellman-Ford relaxation stage. Once relaxation finishes, this block runs one extra relaxation-check pass over the adjacency and vertex memories to find an edge that still relaxes, which means a negative (arbitrage) cycle exists. It then walks the predecessor field of vertmat to land inside the cycle and streams that cycle's vertex IDs to the software-facing result logic over a valid/ready interface. Access is read-only; the top level muxes vertmat/adjmat addresses to this block while `bellman_done` is high.

---
 rtl/cycle_extract_pkg.sv | 28 ++
 rtl/cycle_extract.sv | 179 +++++++++++++++++
 tb/tb_cycle_extract.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_extract_pkg.sv
// Shared widths, vertmat word layout and the relaxation predicate for cycle extraction.
package cycle_extract_pkg;

    localparam int unsigned NODES        = 4;
    localparam int unsigned PRED_WIDTH   = 1;
    localparam int unsigned WEIGHT_WIDTH = 31;
    localparam int unsigned VERT_WIDTH   = PRED_WIDTH + WEIGHT_WIDTH + 1;

    typedef logic [PRED_WIDTH:0]   vid_t;
    typedef logic [WEIGHT_WIDTH:0] weight_t;
    typedef logic [PRED_WIDTH+1:0] len_t;

    // Unreached-vertex sentinel written at setup.
    localparam weight_t INF_WEIGHT = (WEIGHT_WIDTH+1)'('h777f_ffff);

    typedef struct packed {
        vid_t    pred;
        weight_t weight;
    } vert_word_t;

    // Edge still relaxes: wrapping sum compared signed, same as the relaxation stage.
    function automatic logic relaxes(input weight_t svw, input weight_t dvw, input weight_t e);
        weight_t sum;
        sum = svw + e;
        return (e != '0) && (svw != INF_WEIGHT) && ($signed(sum) < $signed(dvw));
    endfunction

endpackage

// File: rtl/cycle_extract.sv
// Negative-cycle detection pass over adjmat/vertmat, then predecessor walk and
// valid/ready streaming of the cycle's vertex IDs.
module cycle_extract
    import cycle_extract_pkg::*;
(
    input  logic                    clk,
    input  logic                    cycle_reset,
    input  logic                    go,
    input  logic [VERT_WIDTH:0]     vertmat_q_a,
    input  logic [VERT_WIDTH:0]     vertmat_q_b,
    input  logic [WEIGHT_WIDTH:0]   adjmat_q,
    output logic [PRED_WIDTH:0]     vertmat_addr_a,
    output logic [PRED_WIDTH:0]     vertmat_addr_b,
    output logic [PRED_WIDTH:0]     adjmat_row_addr,
    output logic [PRED_WIDTH:0]     adjmat_col_addr,
    output logic                    path_valid,
    input  logic                    path_ready,
    output logic [PRED_WIDTH:0]     path_vertex,
    output logic                    path_last,
    output logic                    cycle_found,
    output logic [PRED_WIDTH+1:0]   cycle_len,
    output logic                    cycle_done
);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, WALK_RD, WALK_STEP, EMIT, NEXT_RD, DONE
    } state_t;

    localparam vid_t LAST_ID   = vid_t'(NODES - 1);
    localparam len_t LEN_GUARD = len_t'(NODES - 1);

    state_t state_q, state_d;
    vid_t   i_q, i_d, j_q, j_d, v_q, v_d, tail_q, tail_d, walk_q, walk_d;
    vid_t   addr_a_q, addr_a_d, vertex_q, vertex_d;
    logic   valid_q, valid_d, last_q, last_d, found_q, found_d, done_q, done_d;
    len_t   len_q, len_d;

    vert_word_t word_a;
    weight_t    weight_b;
    logic       unused_pred_b;

    assign word_a        = vert_word_t'(vertmat_q_a);
    assign weight_b      = vertmat_q_b[WEIGHT_WIDTH:0];
    assign unused_pred_b = ^vertmat_q_b[VERT_WIDTH:WEIGHT_WIDTH+1];

    // tail is the walk vertex one step before s: it lies in the cycle and its pred is s,
    // so the beat carrying tail is the one whose next pred wraps back to s.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        v_d      = v_q;
        tail_d   = tail_q;
        walk_d   = walk_q;
        addr_a_d = addr_a_q;
        vertex_d = vertex_q;
        valid_d  = valid_q;
        last_d   = last_q;
        found_d  = found_q;
        done_d   = done_q;
        len_d    = len_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    i_d      = '0;
                    j_d      = '0;
                    addr_a_d = '0;
                    state_d  = SCAN_RD;
                end
            end
            SCAN_RD: state_d = SCAN_CHK;
            SCAN_CHK: begin
                if (relaxes(word_a.weight, weight_b, adjmat_q)) begin
                    v_d      = j_q;
                    walk_d   = '0;
                    addr_a_d = j_q;
                    state_d  = WALK_RD;
                end else if (i_q == LAST_ID && j_q == LAST_ID) begin
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (j_q == LAST_ID) begin
                        j_d = '0;
                        i_d = i_q + vid_t'(1);
                    end else begin
                        j_d = j_q + vid_t'(1);
                    end
                    addr_a_d = i_d;
                    state_d  = SCAN_RD;
                end
            end
            WALK_RD: state_d = WALK_STEP;
            WALK_STEP: begin
                v_d      = word_a.pred;
                addr_a_d = word_a.pred;
                if (walk_q == LAST_ID) begin
                    tail_d   = v_q;
                    found_d  = 1'b1;
                    valid_d  = 1'b1;
                    vertex_d = word_a.pred;
                    last_d   = (word_a.pred == v_q) || (len_q == LEN_GUARD);
                    state_d  = EMIT;
                end else begin
                    walk_d  = walk_q + vid_t'(1);
                    state_d = WALK_RD;
                end
            end
            EMIT: begin
                if (path_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    len_d   = len_q + len_t'(1);
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = NEXT_RD;
                    end
                end
            end
            NEXT_RD: begin
                // addr_a held v through EMIT, so q_a now carries pred(v).
                v_d      = word_a.pred;
                addr_a_d = word_a.pred;
                valid_d  = 1'b1;
                vertex_d = word_a.pred;
                last_d   = (word_a.pred == tail_q) || (len_q == LEN_GUARD);
                state_d  = EMIT;
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cycle_reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            v_q      <= '0;
            tail_q   <= '0;
            walk_q   <= '0;
            addr_a_q <= '0;
            vertex_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            v_q      <= v_d;
            tail_q   <= tail_d;
            walk_q   <= walk_d;
            addr_a_q <= addr_a_d;
            vertex_q <= vertex_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            found_q  <= found_d;
            done_q   <= done_d;
            len_q    <= len_d;
        end
    end

    assign vertmat_addr_a  = addr_a_q;
    assign vertmat_addr_b  = j_q;
    assign adjmat_row_addr = i_q;
    assign adjmat_col_addr = j_q;
    assign path_valid      = valid_q;
    assign path_vertex     = vertex_q;
    assign path_last       = last_q;
    assign cycle_found     = found_q;
    assign cycle_len       = len_q;
    assign cycle_done      = done_q;

endmodule

// File: tb/tb_cycle_extract.sv
// Scenario bench for cycle_extract: 1-cycle-latency RAM model, directed and random
// graphs checked against a graph-level reference model.
module tb_cycle_extract;
    import cycle_extract_pkg::*;

    localparam int OW = 5 * (PRED_WIDTH + 1) + (PRED_WIDTH + 2) + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  cycle_reset, go, path_ready;
    logic [VERT_WIDTH:0]   vertmat_q_a, vertmat_q_b;
    logic [WEIGHT_WIDTH:0] adjmat_q;
    logic [PRED_WIDTH:0]   vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr, path_vertex;
    logic                  path_valid, path_last, cycle_found, cycle_done;
    logic [PRED_WIDTH+1:0] cycle_len;
    logic [OW-1:0]         all_outs;

    cycle_extract dut (
        .clk(clk), .cycle_reset(cycle_reset), .go(go),
        .vertmat_q_a(vertmat_q_a), .vertmat_q_b(vertmat_q_b), .adjmat_q(adjmat_q),
        .vertmat_addr_a(vertmat_addr_a), .vertmat_addr_b(vertmat_addr_b),
        .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
        .path_valid(path_valid), .path_ready(path_ready), .path_vertex(path_vertex),
        .path_last(path_last), .cycle_found(cycle_found), .cycle_len(cycle_len),
        .cycle_done(cycle_done)
    );

    assign all_outs = {vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr,
                       path_valid, path_vertex, path_last, cycle_found, cycle_len, cycle_done};

    // Memory contents and 1-cycle-latency read model.
    logic [WEIGHT_WIDTH:0] adj [NODES][NODES];
    logic [WEIGHT_WIDTH:0] vw  [NODES];
    int                    vp  [NODES];

    always @(posedge clk) begin
        vertmat_q_a <= {vid_t'(vp[vertmat_addr_a]), vw[vertmat_addr_a]};
        vertmat_q_b <= {vid_t'(vp[vertmat_addr_b]), vw[vertmat_addr_b]};
        adjmat_q    <= adj[adjmat_row_addr][adjmat_col_addr];
    end

    int checks = 0;
    int passes = 0;

    int obs_v[$], obs_beat_c[$], obs_hs_c[$];
    bit obs_l[$];
    int obs_done_c, obs_unstable, obs_dropped;
    bit obs_timeout;

    bit exp_found;
    int exp_k;
    int exp_seq[$];

    function automatic logic [WEIGHT_WIDTH:0] wt(input int x);
        return (WEIGHT_WIDTH+1)'(x);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NODES; i++) begin
            vw[i] = '0;
            vp[i] = 0;
            for (int j = 0; j < NODES; j++) adj[i][j] = '0;
        end
    endtask

    task automatic setup_triangle();
        clear_mem();
        adj[0][1] = wt(2); adj[1][2] = wt(-3); adj[2][0] = wt(-1);
        vw[0] = wt(-4); vp[0] = 2;
        vw[1] = wt(-2); vp[1] = 0;
        vw[2] = wt(-5); vp[2] = 1;
        vw[3] = INF_WEIGHT; vp[3] = 0;
    endtask

    // Reference: first relaxing edge in row-major order, NODES pred hops, then follow preds until back at s.
    task automatic model();
        logic [WEIGHT_WIDTH:0] sum;
        int v, s, u;
        exp_seq.delete();
        exp_found = 0;
        exp_k = -1;
        for (int k = 0; k < NODES * NODES; k++) begin
            sum = vw[k / NODES] + adj[k / NODES][k % NODES];
            if (adj[k / NODES][k % NODES] != '0 && vw[k / NODES] != INF_WEIGHT &&
                $signed(sum) < $signed(vw[k % NODES])) begin
                exp_k = k;
                break;
            end
        end
        if (exp_k >= 0) begin
            exp_found = 1;
            v = exp_k % NODES;
            repeat (NODES) v = vp[v];
            s = v;
            exp_seq.push_back(s);
            u = vp[s];
            while (u != s && exp_seq.size() < NODES) begin
                exp_seq.push_back(u);
                u = vp[u];
            end
        end
    endtask

    task automatic do_reset();
        cycle_reset = 1'b1;
        go = 1'b0;
        path_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle_reset = 1'b0;
    endtask

    // Pulse go, then observe until cycle_done; cycle c is the state after the c-th edge past go's sample edge.
    task automatic run_stream(input int stall, input bit rnd);
        bit in_beat;
        int stall_left, hv;
        bit hl;
        obs_v.delete(); obs_l.delete(); obs_beat_c.delete(); obs_hs_c.delete();
        obs_done_c = -1; obs_timeout = 1; obs_unstable = 0; obs_dropped = 0;
        in_beat = 0; stall_left = 0; hv = 0; hl = 0;
        path_ready = 1'b0;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk);
            #1;
            if (cycle_done) begin
                obs_done_c = c;
                obs_timeout = 0;
                break;
            end
            if (in_beat && !path_valid) begin
                obs_dropped++;
                in_beat = 0;
            end
            if (path_valid) begin
                if (!in_beat) begin
                    in_beat = 1;
                    hv = int'(path_vertex);
                    hl = path_last;
                    obs_v.push_back(hv);
                    obs_l.push_back(hl);
                    obs_beat_c.push_back(c);
                    stall_left = rnd ? int'($urandom_range(stall, 0)) : stall;
                end else if (int'(path_vertex) != hv || path_last != hl) begin
                    obs_unstable++;
                end
                if (stall_left == 0) begin
                    path_ready = 1'b1;
                    obs_hs_c.push_back(c);
                    in_beat = 0;
                end else begin
                    path_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                path_ready = 1'b0;
            end
        end
        path_ready = 1'b0;
    endtask

    task automatic test_reset();
        cycle_reset = 1'b1; go = 1'b0; path_ready = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) $display("FAIL reset_outputs: got %h expected 0", all_outs);
        else passes++;
        cycle_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) $display("FAIL idle_hold: got %h expected 0", all_outs);
        else passes++;
    endtask

    task automatic test_triangle();
        int lit[3] = '{2, 1, 0};
        do_reset();
        setup_triangle();
        run_stream(0, 0);
        checks++;
        if (obs_timeout !== 1'b0) $display("FAIL tri_timeout: got %0d expected 0", obs_timeout);
        else passes++;
        checks++;
        if (cycle_found !== 1'b1) $display("FAIL tri_found: got %0d expected 1", cycle_found);
        else passes++;
        checks++;
        if (cycle_len !== 3'd3) $display("FAIL tri_len: got %0d expected 3", cycle_len);
        else passes++;
        checks++;
        if (obs_v.size() !== 3) $display("FAIL tri_beats: got %0d expected 3", obs_v.size());
        else passes++;
        for (int m = 0; m < 3 && m < obs_v.size(); m++) begin
            checks++;
            if (obs_v[m] !== lit[m] || obs_l[m] !== (m == 2))
                $display("FAIL tri_beat%0d: got v%0d last%0d expected v%0d last%0d", m, obs_v[m], obs_l[m], lit[m], m == 2);
            else passes++;
        end
        // hit at (2,0) = pair 8: 2*9 scan cycles + 2*NODES walk cycles
        checks++;
        if (obs_beat_c.size() < 1 || obs_beat_c[0] !== 2 * 8 + 2 + 2 * NODES)
            $display("FAIL tri_first_beat_cycle: got %0d expected %0d", obs_beat_c.size() > 0 ? obs_beat_c[0] : -1, 2 * 8 + 2 + 2 * NODES);
        else passes++;
        for (int m = 1; m < obs_beat_c.size(); m++) begin
            checks++;
            if (obs_beat_c[m] !== obs_hs_c[m - 1] + 2)
                $display("FAIL tri_beat_spacing%0d: got %0d expected %0d", m, obs_beat_c[m], obs_hs_c[m - 1] + 2);
            else passes++;
        end
        checks++;
        if (obs_hs_c.size() < 1 || obs_done_c !== obs_hs_c[obs_hs_c.size() - 1] + 1)
            $display("FAIL tri_done_cycle: got %0d expected last handshake + 1", obs_done_c);
        else passes++;
    endtask

    task automatic test_no_cycle();
        do_reset();
        setup_triangle();
        adj[2][0] = wt(5);
        run_stream(0, 0);
        checks++;
        if (cycle_found !== 1'b0 || cycle_len !== '0)
            $display("FAIL nocyc_found: got found%0d len%0d expected 0 0", cycle_found, cycle_len);
        else passes++;
        checks++;
        if (obs_v.size() !== 0) $display("FAIL nocyc_beats: got %0d expected 0", obs_v.size());
        else passes++;
        checks++;
        if (obs_done_c !== 2 * NODES * NODES)
            $display("FAIL nocyc_done_cycle: got %0d expected %0d", obs_done_c, 2 * NODES * NODES);
        else passes++;
    endtask

    task automatic test_inf_skip();
        do_reset();
        clear_mem();
        adj[3][0] = wt(-10);
        vw[3] = INF_WEIGHT;
        run_stream(0, 0);
        checks++;
        if (cycle_found !== 1'b0 || obs_v.size() !== 0 || obs_done_c !== 2 * NODES * NODES)
            $display("FAIL inf_skip: got found%0d beats%0d done%0d expected 0 0 %0d",
                     cycle_found, obs_v.size(), obs_done_c, 2 * NODES * NODES);
        else passes++;
    endtask

    task automatic test_self_loop();
        do_reset();
        clear_mem();
        adj[3][3] = wt(-1);
        vp[3] = 3;
        run_stream(0, 0);
        checks++;
        if (obs_v.size() !== 1 || obs_v[0] !== 3 || obs_l[0] !== 1'b1)
            $display("FAIL self_beat: got beats%0d v%0d last%0d expected 1 3 1", obs_v.size(), obs_v[0], obs_l[0]);
        else passes++;
        checks++;
        if (cycle_len !== 3'd1 || cycle_found !== 1'b1)
            $display("FAIL self_len: got len%0d found%0d expected 1 1", cycle_len, cycle_found);
        else passes++;
        checks++;
        if (obs_beat_c.size() < 1 || obs_beat_c[0] !== 2 * 15 + 2 + 2 * NODES)
            $display("FAIL self_first_beat_cycle: got %0d expected %0d", obs_beat_c.size() > 0 ? obs_beat_c[0] : -1, 2 * 15 + 2 + 2 * NODES);
        else passes++;
    endtask

    task automatic test_backpressure();
        int lit[3] = '{2, 1, 0};
        do_reset();
        setup_triangle();
        run_stream(5, 0);
        checks++;
        if (obs_unstable !== 0 || obs_dropped !== 0)
            $display("FAIL bp_stable: got unstable%0d dropped%0d expected 0 0", obs_unstable, obs_dropped);
        else passes++;
        checks++;
        if (obs_v.size() !== 3 || cycle_len !== 3'd3 || obs_timeout !== 1'b0)
            $display("FAIL bp_count: got beats%0d len%0d timeout%0d expected 3 3 0", obs_v.size(), cycle_len, obs_timeout);
        else passes++;
        for (int m = 0; m < 3 && m < obs_v.size(); m++) begin
            checks++;
            if (obs_v[m] !== lit[m] || obs_l[m] !== (m == 2) || obs_hs_c[m] !== obs_beat_c[m] + 5)
                $display("FAIL bp_beat%0d: got v%0d last%0d wait%0d expected v%0d last%0d wait5",
                         m, obs_v[m], obs_l[m], obs_hs_c[m] - obs_beat_c[m], lit[m], m == 2);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        int nbeat;
        bit prev_valid, reached;
        do_reset();
        setup_triangle();
        nbeat = 0; prev_valid = 0; reached = 0;
        path_ready = 1'b1;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (path_valid && !prev_valid) nbeat++;
            prev_valid = path_valid;
            if (nbeat == 2) begin
                reached = 1;
                break;
            end
        end
        checks++;
        if (!reached || path_vertex !== 2'd1)
            $display("FAIL midrst_second_beat: got reached%0d v%0d expected 1 1", reached, path_vertex);
        else passes++;
        cycle_reset = 1'b1;
        path_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) $display("FAIL midrst_outputs: got %h expected 0", all_outs);
        else passes++;
        cycle_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) $display("FAIL midrst_idle: got %h expected 0", all_outs);
        else passes++;
        run_stream(0, 0);
        checks++;
        if (obs_v.size() !== 3 || obs_v[0] !== 2 || obs_v[1] !== 1 || obs_v[2] !== 0 || obs_l[2] !== 1'b1 || cycle_len !== 3'd3)
            $display("FAIL midrst_rerun: got beats%0d len%0d expected stream 2,1,0 len3", obs_v.size(), cycle_len);
        else passes++;
    endtask

    task automatic test_random();
        int exp_first;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            clear_mem();
            for (int i = 0; i < NODES; i++) begin
                vw[i] = ($urandom_range(9, 0) == 0) ? INF_WEIGHT : wt(int'($urandom_range(40, 0)) - 20);
                vp[i] = int'($urandom_range(NODES - 1, 0));
                for (int j = 0; j < NODES; j++)
                    if ($urandom_range(99, 0) < 30) adj[i][j] = wt(int'($urandom_range(20, 0)) - 10);
            end
            model();
            run_stream(3, 1);
            checks++;
            if (obs_timeout !== 1'b0 || cycle_found !== exp_found || cycle_len !== (PRED_WIDTH+2)'(exp_seq.size()))
                $display("FAIL rnd%0d_summary: got timeout%0d found%0d len%0d expected 0 %0d %0d",
                         it, obs_timeout, cycle_found, cycle_len, exp_found, exp_seq.size());
            else passes++;
            checks++;
            if (obs_v.size() !== exp_seq.size())
                $display("FAIL rnd%0d_beats: got %0d expected %0d", it, obs_v.size(), exp_seq.size());
            else passes++;
            for (int m = 0; m < exp_seq.size() && m < obs_v.size(); m++) begin
                checks++;
                if (obs_v[m] !== exp_seq[m] || obs_l[m] !== (m == exp_seq.size() - 1))
                    $display("FAIL rnd%0d_beat%0d: got v%0d last%0d expected v%0d last%0d",
                             it, m, obs_v[m], obs_l[m], exp_seq[m], m == exp_seq.size() - 1);
                else passes++;
            end
            exp_first = exp_found ? 2 * exp_k + 2 + 2 * NODES : -1;
            checks++;
            if (exp_found && (obs_beat_c.size() < 1 || obs_beat_c[0] !== exp_first))
                $display("FAIL rnd%0d_first_beat_cycle: got %0d expected %0d", it, obs_beat_c.size() > 0 ? obs_beat_c[0] : -1, exp_first);
            else if (!exp_found && obs_done_c !== 2 * NODES * NODES)
                $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", it, obs_done_c, 2 * NODES * NODES);
            else passes++;
            checks++;
            if (obs_unstable !== 0 || obs_dropped !== 0)
                $display("FAIL rnd%0d_stable: got unstable%0d dropped%0d expected 0 0", it, obs_unstable, obs_dropped);
            else passes++;
        end
    endtask

    initial begin
        cycle_reset = 1'b1;
        go = 1'b0;
        path_ready = 1'b0;
        test_reset();
        test_triangle();
        test_no_cycle();
        test_inf_skip();
        test_self_loop();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
